// File: rtl/spi_frame_receiver.sv
// SPI-style frame receiver: synchronizes an external serial link, assembles
// WIDTH-bit frames (MSB first) and queues complete words in a small show-ahead
// FIFO for the downstream instruction queue.
module spi_frame_receiver #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_in,
    input  logic             cs_in,
    input  logic             sdata_in,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_out,
    output logic             instr_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        COMMIT   = 2'd2,
        WAIT_END = 2'd3
    } state_t;

    // Synchronizer chains, previous-sample flops and startup tracking
    logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic       cs_meta_q, cs_sync_q, cs_prev_q;
    logic       sdata_meta_q, sdata_sync_q;
    logic [1:0] sync_fill_q;
    logic       cs_armed_q;

    // FSM and datapath registers
    state_t             state_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [WIDTH-1:0]   shift_q;
    logic               busy_q;
    logic               frame_err_q;
    logic               overflow_q;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic sclk_rise, cs_rise, cs_fall;
    logic pop, push;

    // A cs rise only counts once cs has been seen low after reset, so a frame
    // already in flight when reset releases is never picked up halfway.
    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign cs_rise   = cs_sync_q & ~cs_prev_q & cs_armed_q;
    assign cs_fall   = ~cs_sync_q & cs_prev_q;

    assign instr_valid = (count_q != '0);
    assign instr_out   = instr_valid ? mem_q[rd_ptr_q] : '0;
    assign pop         = instr_valid & instr_ready;
    // A pop in the commit cycle frees the slot the new word needs.
    assign push        = (state_q == COMMIT) && ((count_q != FULL_COUNT) || pop);

    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

    // Two-flop synchronizers plus edge-detect history; arm cs once seen low
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_meta_q  <= 1'b0;
            sclk_sync_q  <= 1'b0;
            sclk_prev_q  <= 1'b0;
            cs_meta_q    <= 1'b0;
            cs_sync_q    <= 1'b0;
            cs_prev_q    <= 1'b0;
            sdata_meta_q <= 1'b0;
            sdata_sync_q <= 1'b0;
            sync_fill_q  <= 2'b00;
            cs_armed_q   <= 1'b0;
        end else begin
            sclk_meta_q  <= sclk_in;
            sclk_sync_q  <= sclk_meta_q;
            sclk_prev_q  <= sclk_sync_q;
            cs_meta_q    <= cs_in;
            cs_sync_q    <= cs_meta_q;
            cs_prev_q    <= cs_sync_q;
            sdata_meta_q <= sdata_in;
            sdata_sync_q <= sdata_meta_q;
            sync_fill_q  <= {sync_fill_q[0], 1'b1};
            if (sync_fill_q[1] && !cs_sync_q) begin
                cs_armed_q <= 1'b1;
            end
        end
    end

    // Frame FSM: shift bits in, commit the word, wait for cs to drop
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_rise) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                SHIFT: begin
                    // cs fall takes priority over a coincident sclk edge
                    if (cs_fall) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end else if (sclk_rise) begin
                        shift_q   <= {shift_q[WIDTH-2:0], sdata_sync_q};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    if (!push) begin
                        overflow_q <= 1'b1;
                    end
                    state_q <= WAIT_END;
                end
                WAIT_END: begin
                    if (!cs_sync_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next-state for FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage write; contents need no reset since count gates the output
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

endmodule
